// File: rtl/collision_monitor.sv
// collision_monitor
// Frame-level collision detector and game-state controller for the two-car
// game. Counts yellow-traffic / player-car pixel overlaps during scan-out,
// decides crash or no-crash at each frame boundary, and keeps lives, score,
// speed level and the IDLE/PLAY/CRASH/OVER state machine.
module collision_monitor #(
    parameter int HIT_THRESHOLD     = 16,
    parameter int LIVES             = 3,
    parameter int GRACE_FRAMES      = 60,
    parameter int SPEED_STEP_FRAMES = 600,
    parameter int MAX_SPEED         = 7
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pixel_en,
    input  logic        is_car,
    input  logic        is_redcar,
    input  logic        is_bluecar,
    input  logic        start,
    output logic [1:0]  state,
    output logic        crash_pulse,
    output logic        hit_red,
    output logic        hit_blue,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic [2:0]  speed,
    output logic        game_over
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_CRASH = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [7:0]  HIT_TH     = 8'(HIT_THRESHOLD);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
    localparam logic [7:0]  GRACE_INIT = 8'(GRACE_FRAMES);
    localparam logic [16:0] STEP_WRAP  = 17'(SPEED_STEP_FRAMES);
    localparam logic [2:0]  SPEED_MAX  = 3'(MAX_SPEED);

    logic        frame_clk_q;
    logic [7:0]  ov_cnt_q, ov_cnt_d;
    logic        red_seen_q, red_seen_d;
    logic        blue_seen_q, blue_seen_d;
    logic [1:0]  state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic [2:0]  speed_q, speed_d;
    logic [15:0] speed_frames_q, speed_frames_d;
    logic [7:0]  grace_q, grace_d;
    logic        hit_red_q, hit_red_d;
    logic        hit_blue_q, hit_blue_d;
    logic        crash_pulse_q, crash_pulse_d;
    logic        game_over_q, game_over_d;

    logic        frame_tick;
    logic        ov;
    logic        ov_play;
    logic [7:0]  ov_eff;
    logic        red_eff;
    logic        blue_eff;
    logic [16:0] sf_inc;

    // Scan position is carried for debugging only and never affects the game.
    logic unused_debug;
    assign unused_debug = ^{DrawX, DrawY};

    // The current cycle's overlap sample is folded into the frame result so a
    // sample landing on the boundary cycle still counts in the closing frame.
    assign frame_tick = frame_clk & ~frame_clk_q;
    assign ov         = pixel_en & is_car & (is_redcar | is_bluecar);
    assign ov_play    = ov & (state_q == ST_PLAY);
    assign ov_eff     = (ov_play && (ov_cnt_q != 8'hFF)) ? ov_cnt_q + 8'd1 : ov_cnt_q;
    assign red_eff    = red_seen_q | (ov_play & is_redcar);
    assign blue_eff   = blue_seen_q | (ov_play & is_bluecar);
    assign sf_inc     = {1'b0, speed_frames_q} + 17'd1;

    // Per-frame overlap accumulation; restarts at each boundary and outside PLAY.
    always_comb begin
        ov_cnt_d    = 8'd0;
        red_seen_d  = 1'b0;
        blue_seen_d = 1'b0;
        if ((state_q == ST_PLAY) && !frame_tick) begin
            ov_cnt_d    = ov_eff;
            red_seen_d  = red_eff;
            blue_seen_d = blue_eff;
        end
    end

    // Game state machine: start/restart, frame evaluation, grace countdown.
    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        score_d        = score_q;
        speed_d        = speed_q;
        speed_frames_d = speed_frames_q;
        grace_d        = grace_q;
        hit_red_d      = hit_red_q;
        hit_blue_d     = hit_blue_q;
        crash_pulse_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d        = ST_PLAY;
                    lives_d        = LIVES_INIT;
                    score_d        = 16'd0;
                    speed_d        = 3'd1;
                    speed_frames_d = 16'd0;
                    grace_d        = 8'd0;
                    hit_red_d      = 1'b0;
                    hit_blue_d     = 1'b0;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (ov_eff >= HIT_TH) begin
                        crash_pulse_d = 1'b1;
                        hit_red_d     = red_eff;
                        hit_blue_d    = blue_eff;
                        lives_d       = lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_CRASH;
                            grace_d = GRACE_INIT;
                        end
                    end else begin
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
                        if (sf_inc == STEP_WRAP) begin
                            speed_frames_d = 16'd0;
                            if (speed_q < SPEED_MAX) begin
                                speed_d = speed_q + 3'd1;
                            end
                        end else begin
                            speed_frames_d = sf_inc[15:0];
                        end
                    end
                end
            end
            ST_CRASH: begin
                if (frame_tick) begin
                    grace_d = (grace_q == 8'd0) ? 8'd0 : grace_q - 8'd1;
                    if (grace_q <= 8'd1) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        game_over_d = (state_d == ST_OVER);
    end

    // All state and outputs are registered; Reset clears everything at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_clk_q    <= 1'b0;
            ov_cnt_q       <= 8'd0;
            red_seen_q     <= 1'b0;
            blue_seen_q    <= 1'b0;
            state_q        <= ST_IDLE;
            lives_q        <= LIVES_INIT;
            score_q        <= 16'd0;
            speed_q        <= 3'd1;
            speed_frames_q <= 16'd0;
            grace_q        <= 8'd0;
            hit_red_q      <= 1'b0;
            hit_blue_q     <= 1'b0;
            crash_pulse_q  <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            frame_clk_q    <= frame_clk;
            ov_cnt_q       <= ov_cnt_d;
            red_seen_q     <= red_seen_d;
            blue_seen_q    <= blue_seen_d;
            state_q        <= state_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            speed_q        <= speed_d;
            speed_frames_q <= speed_frames_d;
            grace_q        <= grace_d;
            hit_red_q      <= hit_red_d;
            hit_blue_q     <= hit_blue_d;
            crash_pulse_q  <= crash_pulse_d;
            game_over_q    <= game_over_d;
        end
    end

    assign state       = state_q;
    assign crash_pulse = crash_pulse_q;
    assign hit_red     = hit_red_q;
    assign hit_blue    = hit_blue_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign speed       = speed_q;
    assign game_over   = game_over_q;

endmodule
